// File: rtl/addr_watch_event_fifo.sv
// addr_watch_event_fifo
//   Passive AXI4 write-address snoop. Every AW handshake (awvalid & awready)
//   is tested against an inclusive byte window [cfg_base, cfg_limit]. A burst
//   matches when its byte span overlaps the window. Matching bursts pass
//   through a one-deep stage register and are then queued as events in a
//   first-word-fall-through FIFO that a valid/ready consumer drains. Events
//   that arrive while the FIFO is full are counted and flagged, not stored.
//   The module only observes the bus and never drives it.
//
//   Optional build macro: ADDR_WATCH_TIMESTAMP_EN
//     When defined, a free-running 32-bit cycle counter is sampled in the
//     fire cycle, carried with each event and presented on ev_ts. Only
//     ARESET clears this counter; clear does not.
//
// Ports
//   ACLK, ARESET        clock (rising edge), asynchronous active-high reset
//   clear               synchronous flush of FIFO, stage and drop counters
//   cfg_en              window enable; 0 means nothing matches
//   cfg_base/cfg_limit  inclusive window bounds (byte addresses)
//   snoop_aw*           tapped AW channel (valid, ready, addr, len)
//   ev_valid/ev_ready   FIFO head handshake
//   ev_addr/ev_len      head event burst start address and AWLEN
//   ev_count            FIFO occupancy, 0..FIFO_DEPTH
//   drop_count          saturating count of matched events lost to a full FIFO
//   overflow            sticky flag, set by the first drop
//   ev_ts               head event timestamp (timestamp build only)
module addr_watch_event_fifo #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned LEN_WIDTH       = 8,
    parameter int unsigned BEAT_BYTES_LOG2 = 2,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          clear,
    input  logic                          cfg_en,
    input  logic [ADDR_WIDTH-1:0]         cfg_base,
    input  logic [ADDR_WIDTH-1:0]         cfg_limit,
    input  logic                          snoop_awvalid,
    input  logic                          snoop_awready,
    input  logic [ADDR_WIDTH-1:0]         snoop_awaddr,
    input  logic [LEN_WIDTH-1:0]          snoop_awlen,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [ADDR_WIDTH-1:0]         ev_addr,
    output logic [LEN_WIDTH-1:0]          ev_len,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic [CNT_WIDTH-1:0]          drop_count,
    output logic                          overflow
`ifdef ADDR_WATCH_TIMESTAMP_EN
    ,
    output logic [31:0]                   ev_ts
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned EXT_W = ADDR_WIDTH + 1;
`ifdef ADDR_WATCH_TIMESTAMP_EN
    localparam int unsigned ENTRY_W = 32 + ADDR_WIDTH + LEN_WIDTH;
`else
    localparam int unsigned ENTRY_W = ADDR_WIDTH + LEN_WIDTH;
`endif

    // ------------------------------------------------------------------
    // Window match, combinational in the fire cycle
    // ------------------------------------------------------------------
    logic             fire;
    logic             hit;
    logic [EXT_W-1:0] span;
    logic [EXT_W-1:0] burst_end;

    always_comb begin
        fire = snoop_awvalid & snoop_awready;
        // One extra bit keeps bursts that end past the top of the address
        // space from wrapping to a small value and missing the window.
        span      = (EXT_W'(snoop_awlen) + EXT_W'(1)) << BEAT_BYTES_LOG2;
        burst_end = {1'b0, snoop_awaddr} + span - EXT_W'(1);
        // An inverted window (base > limit) is treated as empty.
        hit = cfg_en
            & (cfg_base <= cfg_limit)
            & (snoop_awaddr <= cfg_limit)
            & (burst_end >= {1'b0, cfg_base});
    end

    // ------------------------------------------------------------------
    // Optional free-running timestamp
    // ------------------------------------------------------------------
`ifdef ADDR_WATCH_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] stage_ts;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Stage register and FIFO control
    // ------------------------------------------------------------------
    logic                  stage_hit;
    logic [ADDR_WIDTH-1:0] stage_addr;
    logic [LEN_WIDTH-1:0]  stage_len;

    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [OCC_W-1:0]      count_next;
    logic [ENTRY_W-1:0]    entry_in;

    always_comb begin
        full = (ev_count == OCC_W'(FIFO_DEPTH));
        pop  = ev_valid & ev_ready;
        // A full FIFO still accepts a push when the head leaves on the
        // same edge; the write lands in the slot being vacated.
        push = stage_hit & (~full | pop);
        drop = stage_hit & full & ~pop;

        count_next = ev_count;
        unique case ({push, pop})
            2'b10:   count_next = ev_count + OCC_W'(1);
            2'b01:   count_next = ev_count - OCC_W'(1);
            default: count_next = ev_count;
        endcase

`ifdef ADDR_WATCH_TIMESTAMP_EN
        entry_in = {stage_ts, stage_addr, stage_len};
`else
        entry_in = {stage_addr, stage_len};
`endif
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            stage_hit  <= 1'b0;
            stage_addr <= '0;
            stage_len  <= '0;
`ifdef ADDR_WATCH_TIMESTAMP_EN
            stage_ts   <= '0;
`endif
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            ev_count   <= '0;
            ev_valid   <= 1'b0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            // A fire coincident with clear is discarded with the stage.
            stage_hit  <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            ev_count   <= '0;
            ev_valid   <= 1'b0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            stage_hit <= fire & hit;
            if (fire) begin
                stage_addr <= snoop_awaddr;
                stage_len  <= snoop_awlen;
`ifdef ADDR_WATCH_TIMESTAMP_EN
                stage_ts   <= ts_cnt;
`endif
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            ev_count <= count_next;
            ev_valid <= (count_next != '0);

            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + CNT_WIDTH'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Event storage (no reset; head is masked while empty)
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0] head;

    always_ff @(posedge ACLK) begin
        if (push & ~clear) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    always_comb begin
        head    = mem[rd_ptr];
        ev_len  = ev_valid ? head[LEN_WIDTH-1:0] : '0;
        ev_addr = ev_valid ? head[LEN_WIDTH +: ADDR_WIDTH] : '0;
`ifdef ADDR_WATCH_TIMESTAMP_EN
        ev_ts   = ev_valid ? head[LEN_WIDTH + ADDR_WIDTH +: 32] : '0;
`endif
    end

endmodule

// File: tb/tb_addr_watch_event_fifo.sv
// Testbench for addr_watch_event_fifo (default build, no timestamp).
// Table of single-burst match vectors, hand-written multi-cycle sequences
// for overflow, full push/pop, reset and clear, then a randomized run
// against a queue-based event model.
module tb_addr_watch_event_fifo;

    localparam int unsigned DEPTH = 16;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        clear = 1'b0;
    logic        cfg_en = 1'b0;
    logic [31:0] cfg_base = '0;
    logic [31:0] cfg_limit = '0;
    logic        snoop_awvalid = 1'b0;
    logic        snoop_awready = 1'b0;
    logic [31:0] snoop_awaddr = '0;
    logic [7:0]  snoop_awlen = '0;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic [31:0] ev_addr;
    logic [7:0]  ev_len;
    logic [4:0]  ev_count;
    logic [15:0] drop_count;
    logic        overflow;

    always #5 ACLK = ~ACLK;

    addr_watch_event_fifo #(
        .ADDR_WIDTH      (32),
        .LEN_WIDTH       (8),
        .BEAT_BYTES_LOG2 (2),
        .FIFO_DEPTH      (DEPTH),
        .CNT_WIDTH       (16)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .clear         (clear),
        .cfg_en        (cfg_en),
        .cfg_base      (cfg_base),
        .cfg_limit     (cfg_limit),
        .snoop_awvalid (snoop_awvalid),
        .snoop_awready (snoop_awready),
        .snoop_awaddr  (snoop_awaddr),
        .snoop_awlen   (snoop_awlen),
        .ev_valid      (ev_valid),
        .ev_ready      (ev_ready),
        .ev_addr       (ev_addr),
        .ev_len        (ev_len),
        .ev_count      (ev_count),
        .drop_count    (drop_count),
        .overflow      (overflow)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic fire(input logic [31:0] a, input logic [7:0] l);
        snoop_awvalid = 1'b1;
        snoop_awready = 1'b1;
        snoop_awaddr  = a;
        snoop_awlen   = l;
    endtask

    task automatic idle();
        snoop_awvalid = 1'b0;
        snoop_awready = 1'b0;
    endtask

    // Reference: a burst covers bytes [addr, addr + (len+1)*4 - 1]; it is an
    // event when that range shares at least one byte with [base, limit].
    function automatic bit ref_match(input bit en, input longint unsigned base,
                                     input longint unsigned limit, input longint unsigned addr,
                                     input longint unsigned len);
        longint unsigned last;
        last = addr + (len + 1) * 4 - 1;
        return en && (base <= limit) && (addr <= limit) && (last >= base);
    endfunction

    typedef struct {
        bit          en;
        logic [31:0] base;
        logic [31:0] limit;
        logic [31:0] addr;
        logic [7:0]  len;
        bit          exp_hit;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ent_t;

    vec_t vecs[12];
    ent_t q[$];
    bit   pend;
    ent_t pend_e;
    int unsigned drops;
    bit   ovf;

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0000_00FF, 32'h0000_0000, 8'd7,   1'b1};
        vecs[1]  = '{1'b1, 32'h0000_0100, 32'h0000_01FF, 32'h0000_00E0, 8'd7,   1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0100, 32'h0000_01FF, 32'h0000_00E4, 8'd7,   1'b1};
        vecs[3]  = '{1'b1, 32'h0000_0100, 32'h0000_01FF, 32'h0000_0200, 8'd0,   1'b0};
        vecs[4]  = '{1'b1, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 8'd7,   1'b1};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0010, 8'd0,   1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0200, 32'h0000_0100, 32'h0000_0150, 8'd0,   1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0100, 32'h0000_01FF, 32'h0000_01FF, 8'd0,   1'b1};
        vecs[8]  = '{1'b1, 32'h0000_0100, 32'h0000_01FF, 32'h0000_00FC, 8'd0,   1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0100, 32'h0000_01FF, 32'h0000_00FD, 8'd0,   1'b1};
        vecs[10] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 8'd255, 1'b1};
        vecs[11] = '{1'b1, 32'h0000_1000, 32'h0000_1000, 32'h0000_0000, 8'd255, 1'b0};

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_valid", ev_valid, 0);
        chk("rst_count", ev_count, 0);
        chk("rst_addr", ev_addr, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_ovf", overflow, 0);
        ARESET = 1'b0;
        step();

        // ---------------- single-burst vectors ----------------
        for (int i = 0; i < 12; i++) begin
            cfg_en    = vecs[i].en;
            cfg_base  = vecs[i].base;
            cfg_limit = vecs[i].limit;
            fire(vecs[i].addr, vecs[i].len);
            step();
            idle();
            chk($sformatf("vec%0d_latency", i), ev_valid, 0);
            step();
            chk($sformatf("vec%0d_valid", i), ev_valid, vecs[i].exp_hit);
            chk($sformatf("vec%0d_count", i), ev_count, vecs[i].exp_hit ? 1 : 0);
            if (vecs[i].exp_hit) begin
                chk($sformatf("vec%0d_addr", i), ev_addr, vecs[i].addr);
                chk($sformatf("vec%0d_len", i), ev_len, vecs[i].len);
            end
            ev_ready = 1'b1;
            step();
            ev_ready = 1'b0;
            chk($sformatf("vec%0d_drained", i), ev_count, 0);
        end

        // ---------------- overflow: 18 hits into 16 slots ----------------
        cfg_en = 1'b1;
        cfg_base = 32'h0;
        cfg_limit = 32'hFFFF;
        for (int i = 0; i < 18; i++) begin
            fire(32'h100 + 32'(i) * 32'h10, 8'd0);
            step();
        end
        idle();
        step();
        step();
        chk("ovf_count", ev_count, 16);
        chk("ovf_drop", drop_count, 2);
        chk("ovf_flag", overflow, 1);
        ev_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_pop%0d", i), ev_addr, 32'h100 + 32'(i) * 32'h10);
            step();
        end
        ev_ready = 1'b0;
        chk("ovf_empty", ev_count, 0);
        chk("ovf_sticky", overflow, 1);

        // ---------------- full FIFO, push and pop on the same edge ----------------
        for (int i = 0; i < 16; i++) begin
            fire(32'h1000 + 32'(i) * 32'h10, 8'd1);
            step();
        end
        idle();
        step();
        step();
        chk("full_count", ev_count, 16);
        fire(32'h990, 8'd3);
        step();
        idle();
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        chk("pp_count", ev_count, 16);
        chk("pp_drop", drop_count, 2);
        chk("pp_head", ev_addr, 32'h1010);
        ev_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("pp_pop%0d", i), ev_addr, 32'h1000 + 32'(i) * 32'h10);
            step();
        end
        chk("pp_last_addr", ev_addr, 32'h990);
        chk("pp_last_len", ev_len, 3);
        chk("pp_last_count", ev_count, 1);
        step();
        ev_ready = 1'b0;
        chk("pp_empty", ev_count, 0);

        // ---------------- asynchronous reset mid-stream ----------------
        for (int i = 0; i < 5; i++) begin
            fire(32'h2000 + 32'(i) * 32'h10, 8'd0);
            step();
        end
        idle();
        step();
        step();
        chk("ar_pre_count", ev_count, 5);
        #3;
        ARESET = 1'b1;
        #1;
        chk("ar_valid", ev_valid, 0);
        chk("ar_count", ev_count, 0);
        chk("ar_addr", ev_addr, 0);
        chk("ar_len", ev_len, 0);
        chk("ar_drop", drop_count, 0);
        chk("ar_ovf", overflow, 0);
        step();
        ARESET = 1'b0;
        fire(32'h3000, 8'd1);
        step();
        idle();
        step();
        chk("ar_post_valid", ev_valid, 1);
        chk("ar_post_addr", ev_addr, 32'h3000);

        // ---------------- clear mid-stream with a concurrent fire ----------------
        for (int i = 0; i < 17; i++) begin
            fire(32'h4000 + 32'(i) * 32'h10, 8'd0);
            step();
        end
        idle();
        step();
        step();
        chk("clr_pre_count", ev_count, 16);
        chk("clr_pre_drop", drop_count, 2);
        clear = 1'b1;
        fire(32'h777, 8'd0);
        step();
        clear = 1'b0;
        idle();
        chk("clr_count", ev_count, 0);
        chk("clr_valid", ev_valid, 0);
        chk("clr_drop", drop_count, 0);
        chk("clr_ovf", overflow, 0);
        step();
        step();
        chk("clr_fire_discarded", ev_count, 0);

        // ---------------- randomized run against the event model ----------------
        pend = 1'b0;
        drops = 0;
        ovf = 1'b0;
        q.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if ($urandom_range(0, 39) == 0) begin
                cfg_en    = ($urandom_range(0, 7) != 0);
                cfg_base  = 32'($urandom_range(0, 32'h300));
                cfg_limit = 32'($urandom_range(0, 32'h600));
            end
            clear         = ($urandom_range(0, 149) == 0);
            snoop_awvalid = 1'($urandom_range(0, 1));
            snoop_awready = ($urandom_range(0, 3) != 0);
            snoop_awaddr  = 32'($urandom_range(0, 32'h700));
            snoop_awlen   = 8'($urandom_range(0, 15));
            if (((cyc / 250) % 2) == 1) ev_ready = ($urandom_range(0, 7) == 0);
            else ev_ready = ($urandom_range(0, 2) != 0);

            if (clear) begin
                q.delete();
                pend = 1'b0;
                drops = 0;
                ovf = 1'b0;
            end else begin
                if (q.size() > 0 && ev_ready) void'(q.pop_front());
                if (pend) begin
                    if (q.size() < DEPTH) q.push_back(pend_e);
                    else begin
                        ovf = 1'b1;
                        if (drops != 65535) drops++;
                    end
                end
                pend = snoop_awvalid && snoop_awready &&
                       ref_match(cfg_en, cfg_base, cfg_limit, snoop_awaddr, snoop_awlen);
                pend_e.addr = snoop_awaddr;
                pend_e.len  = snoop_awlen;
            end
            step();
            chk("rnd_valid", ev_valid, (q.size() > 0) ? 1 : 0);
            chk("rnd_count", ev_count, q.size());
            chk("rnd_drop", drop_count, drops);
            chk("rnd_ovf", overflow, ovf);
            if (q.size() > 0) begin
                chk("rnd_addr", ev_addr, q[0].addr);
                chk("rnd_len", ev_len, q[0].len);
            end
        end
        clear = 1'b0;
        idle();
        ev_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
